// File: rtl/sseg_serial_driver_if.sv
// CPU-side request/status and serial chain signals
// of the seven-segment serial driver.
interface sseg_serial_driver_if #(
  parameter int DIGITS = 8
);
  logic                  start;
  logic [4*DIGITS-1:0]   hexs;
  logic [DIGITS-1:0]     points;
  logic [DIGITS-1:0]     LEs;
  logic [DIGITS-1:0]     blink;
  logic                  raw_mode;
  logic [8*DIGITS-1:0]   raw_seg;
  logic                  sclk;
  logic                  sclrn;
  logic                  sout;
  logic                  EN;
  logic                  busy;
  logic                  done;

  modport master (
    output start, hexs, points, LEs, blink,
    output raw_mode, raw_seg,
    input  sclk, sclrn, sout, EN, busy, done
  );

  modport slave (
    input  start, hexs, points, LEs, blink,
    input  raw_mode, raw_seg,
    output sclk, sclrn, sout, EN, busy, done
  );
endinterface

// File: rtl/sseg_serial_driver.sv
// Seven-segment serial driver: encodes DIGITS bytes
// and shifts them out to an external shift chain.
module sseg_serial_driver #(
  parameter int DIGITS       = 8,
  parameter int CLK_DIV      = 2,
  parameter int REFRESH      = 0,
  parameter int BLINK_FRAMES = 16
) (
  input  logic                clk,
  input  logic                rst,
  sseg_serial_driver_if.slave bus
);

  localparam int NB = 8 * DIGITS;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(NB + 1);
  localparam int RW = (REFRESH > 0) ? $clog2(REFRESH + 1) : 1;
  localparam int FW = $clog2(BLINK_FRAMES + 1);

  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_ALL   = BW'(NB);
  localparam logic [RW-1:0] IDLE_LAST =
    RW'((REFRESH > 0) ? REFRESH - 1 : 0);
  localparam logic [FW-1:0] FRM_LAST  = FW'(BLINK_FRAMES - 1);

  typedef enum logic [1:0] {
    IDLE, LOAD, SHIFT, LATCH
  } state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] div_cnt;
  logic [BW-1:0] bit_cnt;
  logic [RW-1:0] idle_cnt;
  logic [FW-1:0] frm_cnt;
  logic          phase;
  logic          half;
  logic [NB-1:0] shreg;
  logic [NB-1:0] frame;
  logic          tick;
  logic          last_bit;
  logic          go;
  logic          sclk_q, sclrn_q, sout_q;
  logic          en_q, busy_q, done_q;

  function automatic logic [7:0] hex7(input logic [3:0] h);
    logic [7:0] b;
    unique case (h)
      4'h0: b = 8'hC0;
      4'h1: b = 8'hF9;
      4'h2: b = 8'hA4;
      4'h3: b = 8'hB0;
      4'h4: b = 8'h99;
      4'h5: b = 8'h92;
      4'h6: b = 8'h82;
      4'h7: b = 8'hF8;
      4'h8: b = 8'h80;
      4'h9: b = 8'h90;
      4'hA: b = 8'h88;
      4'hB: b = 8'h83;
      4'hC: b = 8'hC6;
      4'hD: b = 8'hA1;
      4'hE: b = 8'h86;
      4'hF: b = 8'h8E;
    endcase
    return b;
  endfunction

  always_comb begin
    frame = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bus.raw_mode)
        frame[8*i+:8] = bus.raw_seg[8*i+:8];
      else if (bus.LEs[i] || (bus.blink[i] && phase))
        frame[8*i+:8] = 8'hFF;
      else begin
        frame[8*i+:8] = hex7(bus.hexs[4*i+:4]);
        if (bus.points[i])
          frame[8*i+7] = 1'b0;
      end
    end
  end

  always_comb begin
    tick      = (div_cnt == DIV_LAST);
    last_bit  = (bit_cnt == BIT_ALL);
    go        = bus.start ||
                ((REFRESH > 0) && (idle_cnt == IDLE_LAST));
    state_nxt = state;
    unique case (state)
      IDLE:    if (go) state_nxt = LOAD;
      LOAD:    state_nxt = SHIFT;
      SHIFT:   if (tick && !half && last_bit)
                 state_nxt = LATCH;
      LATCH:   if (tick) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_q   <= 1'b1;
      sout_q   <= 1'b1;
      en_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sclrn_q  <= 1'b0;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      idle_cnt <= '0;
      frm_cnt  <= '0;
      phase    <= 1'b0;
      half     <= 1'b0;
      shreg    <= '0;
    end else begin
      sclrn_q <= 1'b1;
      done_q  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (go)
            idle_cnt <= '0;
          else if (REFRESH > 0)
            idle_cnt <= idle_cnt + 1'b1;
        end
        LOAD: begin
          shreg   <= frame;
          busy_q  <= 1'b1;
          en_q    <= 1'b0;
          // first SHIFT edge drops sclk at once
          div_cnt <= DIV_LAST;
          half    <= 1'b0;
          bit_cnt <= '0;
        end
        SHIFT: begin
          if (!tick)
            div_cnt <= div_cnt + 1'b1;
          else begin
            div_cnt <= '0;
            if (half) begin
              sclk_q  <= 1'b1;
              half    <= 1'b0;
              bit_cnt <= bit_cnt + 1'b1;
            end else if (!last_bit) begin
              sclk_q <= 1'b0;
              sout_q <= shreg[NB-1];
              shreg  <= {shreg[NB-2:0], 1'b0};
              half   <= 1'b1;
            end
          end
        end
        LATCH: begin
          if (!tick)
            div_cnt <= div_cnt + 1'b1;
          else begin
            div_cnt <= '0;
            en_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            if (frm_cnt == FRM_LAST) begin
              frm_cnt <= '0;
              phase   <= ~phase;
            end else
              frm_cnt <= frm_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.sclk  = sclk_q;
  assign bus.sclrn = sclrn_q;
  assign bus.sout  = sout_q;
  assign bus.EN    = en_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_sseg_serial_driver.sv
// Bench for sseg_serial_driver: vector table, random
// frames vs a reference model, and handshake corners.
module tb_sseg_serial_driver;

  localparam int D        = 8;
  localparam int CD       = 2;
  localparam int NB       = 8 * D;
  localparam int REF      = 100;
  localparam int BF0      = 16;
  localparam int BF1      = 2;
  localparam int BUSY_LEN = (16 * D + 1) * CD + 1;
  localparam int DONE_OFS = 2 + (16 * D + 1) * CD;
  localparam logic [127:0] DEC_ALL =
    128'hC0F9A4B0999282F880908883C6A1868E;

  typedef struct {
    logic [4*D-1:0] hexs;
    logic [D-1:0]   points;
    logic [D-1:0]   les;
    logic [D-1:0]   blink;
    logic           raw;
    logic [NB-1:0]  raw_seg;
    logic [NB-1:0]  exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sseg_serial_driver_if #(.DIGITS(D)) bus0 ();
  sseg_serial_driver_if #(.DIGITS(D)) bus1 ();

  sseg_serial_driver #(
    .DIGITS(D), .CLK_DIV(CD),
    .REFRESH(0), .BLINK_FRAMES(BF0)
  ) dut0 (.clk(clk), .rst(rst), .bus(bus0));

  sseg_serial_driver #(
    .DIGITS(D), .CLK_DIV(CD),
    .REFRESH(REF), .BLINK_FRAMES(BF1)
  ) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  int npass = 0;
  int ntotal = 0;
  int cyc = 0;
  int frames0 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // dut0 observation
  logic [NB-1:0] bits0 = '0;
  int nrise0, nbusy0, nen0, ndone0;
  int busy_rise0[$];
  int done_at0[$];
  int fall_at0[$];
  logic ps0 = 1'b1;
  logic pb0 = 1'b0;

  always @(negedge clk) begin
    if (bus0.sclk && !ps0) begin
      bits0 = {bits0[NB-2:0], bus0.sout};
      nrise0++;
    end
    if (!bus0.sclk && ps0) fall_at0.push_back(cyc);
    ps0 = bus0.sclk;
    if (bus0.busy) nbusy0++;
    if (!bus0.EN) nen0++;
    if (bus0.busy && !pb0) busy_rise0.push_back(cyc);
    pb0 = bus0.busy;
    if (bus0.done) begin
      ndone0++;
      done_at0.push_back(cyc);
    end
  end

  // dut1 observation
  logic [NB-1:0] bits1 = '0;
  logic [NB-1:0] frames1[$];
  int busy_rise1[$];
  logic ps1 = 1'b1;
  logic pb1 = 1'b0;

  always @(negedge clk) begin
    if (bus1.sclk && !ps1)
      bits1 = {bits1[NB-2:0], bus1.sout};
    ps1 = bus1.sclk;
    if (bus1.busy && !pb1) busy_rise1.push_back(cyc);
    pb1 = bus1.busy;
    if (bus1.done) frames1.push_back(bits1);
  end

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h",
                  nm, act, exp);
  endtask

  function automatic int first(input int q[$]);
    return (q.size() > 0) ? q[0] : -1;
  endfunction

  function automatic logic [NB-1:0] model(
    input logic [4*D-1:0] hexs,
    input logic [D-1:0]   points,
    input logic [D-1:0]   les,
    input logic [D-1:0]   blink,
    input logic           raw,
    input logic [NB-1:0]  raw_seg,
    input logic           ph
  );
    logic [127:0]  dec;
    logic [NB-1:0] f;
    logic [7:0]    b;
    int            h;
    dec = DEC_ALL;
    f = '0;
    for (int i = 0; i < D; i++) begin
      h = int'(hexs[4*i+:4]);
      b = dec[8*(15-h)+:8];
      if (points[i]) b = b & 8'h7F;
      if (les[i] || (blink[i] && ph)) b = 8'hFF;
      if (raw) b = raw_seg[8*i+:8];
      f[8*i+:8] = b;
    end
    return f;
  endfunction

  task automatic clear0();
    bits0 = '0;
    nrise0 = 0; nbusy0 = 0; nen0 = 0; ndone0 = 0;
    busy_rise0.delete();
    done_at0.delete();
    fall_at0.delete();
  endtask

  task automatic apply0(input vec_t v);
    bus0.hexs     = v.hexs;
    bus0.points   = v.points;
    bus0.LEs      = v.les;
    bus0.blink    = v.blink;
    bus0.raw_mode = v.raw;
    bus0.raw_seg  = v.raw_seg;
  endtask

  task automatic run_frame(input vec_t v, input string nm,
                           input int pulse_at, input int post);
    int k;
    apply0(v);
    clear0();
    @(posedge clk); #2 bus0.start = 1'b1;
    @(posedge clk); #2;
    k = cyc;
    bus0.start = 1'b0;
    for (int t = 0; t < BUSY_LEN + 20; t++) begin
      @(posedge clk); #2;
      bus0.start = (t == pulse_at);
      if (ndone0 != 0) break;
    end
    bus0.start = 1'b0;
    repeat (post) @(posedge clk);
    #2;
    chk({nm, "_bits"}, bits0, v.exp);
    chk({nm, "_rises"}, nrise0, NB);
    chk({nm, "_busy_len"}, nbusy0, BUSY_LEN);
    chk({nm, "_en_low"}, nen0, BUSY_LEN);
    chk({nm, "_done_cnt"}, ndone0, 1);
    chk({nm, "_busy_rise"}, first(busy_rise0), k + 1);
    chk({nm, "_first_fall"}, first(fall_at0), k + 2);
    chk({nm, "_done_at"}, first(done_at0), k + DONE_OFS);
    frames0++;
  endtask

  vec_t tab[5];
  vec_t v;

  initial begin
    tab[0] = '{32'h01234567, 8'h00, 8'h00, 8'h00, 1'b0,
               64'h0, 64'hC0F9A4B0999282F8};
    tab[1] = '{32'h01234567, 8'h01, 8'h80, 8'h00, 1'b0,
               64'h0, 64'hFFF9A4B099928278};
    tab[2] = '{32'h01234567, 8'h00, 8'hFF, 8'h00, 1'b1,
               64'hA55A_0F0F_F0F0_1234,
               64'hA55A_0F0F_F0F0_1234};
    tab[3] = '{32'h89ABCDEF, 8'h00, 8'h00, 8'h00, 1'b0,
               64'h0, 64'h80908883C6A1868E};
    tab[4] = '{32'h00000000, 8'h00, 8'h00, 8'hFF, 1'b0,
               64'h0, 64'hC0C0C0C0C0C0C0C0};

    bus0.start = 1'b0;
    apply0(tab[0]);
    bus1.start    = 1'b0;
    bus1.hexs     = 32'h01234567;
    bus1.points   = '0;
    bus1.LEs      = '0;
    bus1.blink    = 8'h01;
    bus1.raw_mode = 1'b0;
    bus1.raw_seg  = '0;

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_outs0", {bus0.sclk, bus0.sout, bus0.EN,
        bus0.busy, bus0.done, bus0.sclrn}, 6'b111000);
    chk("reset_outs1", {bus1.sclk, bus1.sout, bus1.EN,
        bus1.busy, bus1.done, bus1.sclrn}, 6'b111000);
    frames1.delete();
    busy_rise1.delete();
    rst = 1'b0;
    #1 chk("sclrn_before_edge", bus0.sclrn, 1'b0);
    @(posedge clk); #2;
    chk("sclrn_after_edge", bus0.sclrn, 1'b1);

    // autonomous refresh with blink on dut1
    for (int t = 0; t < 7 * (BUSY_LEN + REF + 1) + 200; t++) begin
      if (frames1.size() >= 6) break;
      @(posedge clk);
    end
    #2;
    chk("refresh_frames", frames1.size(), 6);
    for (int j = 0; j < 6; j++)
      if (j < frames1.size())
        chk($sformatf("refresh_frame%0d", j + 1), frames1[j],
            model(32'h01234567, 8'h00, 8'h00, 8'h01, 1'b0,
                  64'h0, 1'((j / BF1) % 2)));
    for (int j = 0; j < 5; j++)
      if (j + 1 < busy_rise1.size())
        chk($sformatf("refresh_gap%0d", j + 1),
            busy_rise1[j+1] - busy_rise1[j],
            BUSY_LEN + REF + 1);

    for (int i = 0; i < 5; i++)
      run_frame(tab[i], $sformatf("tab%0d", i), -1, 5);

    for (int i = 0; i < 14; i++) begin
      v.hexs    = $urandom;
      v.points  = 8'($urandom);
      v.les     = 8'($urandom) & 8'($urandom);
      v.blink   = 8'($urandom);
      v.raw     = ($urandom_range(0, 3) == 0);
      v.raw_seg = {$urandom, $urandom};
      v.exp     = model(v.hexs, v.points, v.les, v.blink,
                        v.raw, v.raw_seg,
                        1'((frames0 / BF0) % 2));
      run_frame(v, $sformatf("rnd%0d", i), -1, 3);
    end

    // start held high
    apply0(tab[0]);
    clear0();
    @(posedge clk); #2 bus0.start = 1'b1;
    repeat (300) @(posedge clk);
    #2 bus0.start = 1'b0;
    for (int t = 0; t < 2 * BUSY_LEN + 50; t++) begin
      if (ndone0 >= 2) break;
      @(posedge clk);
    end
    repeat (300) @(posedge clk);
    #2;
    chk("held_done_cnt", ndone0, 2);
    chk("held_busy_rises", busy_rise0.size(), 2);
    if (busy_rise0.size() > 1 && done_at0.size() > 0)
      chk("held_restart_gap", busy_rise0[1] - done_at0[0], 2);
    frames0 += 2;

    // single start pulse mid-frame
    v = tab[3];
    v.exp = model(v.hexs, v.points, v.les, v.blink, v.raw,
                  v.raw_seg, 1'((frames0 / BF0) % 2));
    run_frame(v, "midpulse", 100, 300);

    // reset during bit 20
    apply0(tab[1]);
    clear0();
    @(posedge clk); #2 bus0.start = 1'b1;
    @(posedge clk); #2 bus0.start = 1'b0;
    for (int t = 0; t < 200; t++) begin
      if (nrise0 >= 20) break;
      @(posedge clk); #2;
    end
    repeat (CD + 1) @(posedge clk);
    #2;
    chk("rstmid_rises", nrise0, 20);
    chk("rstmid_busy", bus0.busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("rstmid_outs", {bus0.sclk, bus0.sout, bus0.EN,
        bus0.busy, bus0.done, bus0.sclrn}, 6'b111000);
    @(posedge clk); #2 rst = 1'b0;
    frames0 = 0;
    run_frame(tab[1], "post_rst", -1, 5);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
